// File: rtl/arp_note_scheduler_if.sv
// arp_note_scheduler_if: control/status bundle between the arpeggiator
// scheduler (slave side) and whatever drives its controls (master side).
interface arp_note_scheduler_if #(
    parameter int ADDR_W = 8
);
    logic              arp_toggle;
    logic [7:0]        base_sel;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addra;
    logic              addr_step;
    logic [1:0]        note;
    logic              arp_on;
    logic              mute;

    modport master (
        output arp_toggle, base_sel, mode,
        input  addra, addr_step, note, arp_on, mute
    );

    modport slave (
        input  arp_toggle, base_sel, mode,
        output addra, addr_step, note, arp_on, mute
    );
endinterface

// File: rtl/arp_note_scheduler.sv
// arp_note_scheduler: sine-BRAM read-address sequencer with a four-note
// arpeggiator (root, 5/4, 3/2, octave). Each sample lasts P clocks, where P
// is derived from the latched base half-period and the current note.
// Optional end-of-note gate: define ARP_GATE_EN to mute and freeze the
// address stream for the last GATE_TICKS clocks of every arpeggio note.
module arp_note_scheduler #(
    parameter int ADDR_W     = 8,
    parameter int DIV_W      = 13,
    parameter int BASE_DIV   = 746,
    parameter int NOTE_TICKS = 50000000
`ifdef ARP_GATE_EN
    ,
    parameter int GATE_TICKS = 5000000
`endif
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    arp_note_scheduler_if.slave bus
);
    // f_lat holds BASE_DIV + 255 at most; products keep three extra bits.
    localparam int F_W    = $clog2(BASE_DIV + 256);
    localparam int PROD_W = (F_W + 4 > 14) ? F_W + 4 : 14;
    localparam int TMR_W  = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(NOTE_TICKS - 1);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    logic              tog_s1_q, tog_s2_q, tog_s3_q;
    logic              tog_rise;
    logic              arp_on_q, arp_on_d;
    logic [1:0]        note_q, note_d;
    dir_e              dir_q, dir_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic              step_q, step_d;
    logic [F_W-1:0]    f_lat_q, f_lat_d;
    logic [PROD_W-1:0] f_ext, p_full;
    logic [DIV_W-1:0]  period_m1;
    logic              run;

    // Sample period for the current note, floored ratio of the latched base.
    always_comb begin
        f_ext  = PROD_W'(f_lat_q);
        p_full = f_ext;
        case (note_q)
            2'd0:    p_full = f_ext << 1;
            2'd1:    p_full = (f_ext << 3) / PROD_W'(5);
            2'd2:    p_full = (f_ext << 2) / PROD_W'(3);
            default: p_full = f_ext;
        endcase
        period_m1 = DIV_W'(p_full) - DIV_W'(1);
    end

    // Next state: divider/address advance, then note scheduling (which may
    // override the divider), with the toggle edge taking priority over all
    // note activity.
    always_comb begin
        tog_rise = tog_s2_q & ~tog_s3_q;
        arp_on_d = arp_on_q ^ tog_rise;
        note_d   = note_q;
        dir_d    = dir_q;
        timer_d  = timer_q;
        div_d    = div_q;
        addra_d  = addra_q;
        step_d   = 1'b0;
        f_lat_d  = f_lat_q;

        if (run) begin
            if (div_q >= period_m1) begin
                div_d   = '0;
                addra_d = addra_q + ADDR_W'(1);
                step_d  = 1'b1;
                // New base only at a sample boundary so no sample is distorted.
                f_lat_d = F_W'(BASE_DIV) + F_W'(bus.base_sel);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        if (tog_rise || !arp_on_q) begin
            note_d  = 2'd0;
            timer_d = '0;
            dir_d   = DIR_UP;
        end else if (timer_q == TMR_LAST) begin
            timer_d = '0;
            // Restart the sample on the new pitch; addra keeps its phase.
            div_d   = '0;
            case (bus.mode)
                2'b00: note_d = note_q + 2'd1;
                2'b01: note_d = note_q - 2'd1;
                2'b10: begin
                    if (dir_q == DIR_UP) begin
                        if (note_q == 2'd3) begin
                            note_d = 2'd2;
                            dir_d  = DIR_DOWN;
                        end else begin
                            note_d = note_q + 2'd1;
                        end
                    end else begin
                        if (note_q == 2'd0) begin
                            note_d = 2'd1;
                            dir_d  = DIR_UP;
                        end else begin
                            note_d = note_q - 2'd1;
                        end
                    end
                end
                default: note_d = note_q;
            endcase
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // State registers, including the two-flop toggle synchroniser.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tog_s1_q <= 1'b0;
            tog_s2_q <= 1'b0;
            tog_s3_q <= 1'b0;
            arp_on_q <= 1'b0;
            note_q   <= 2'd0;
            dir_q    <= DIR_UP;
            timer_q  <= '0;
            div_q    <= '0;
            addra_q  <= '0;
            step_q   <= 1'b0;
            f_lat_q  <= F_W'(BASE_DIV);
        end else begin
            tog_s1_q <= bus.arp_toggle;
            tog_s2_q <= tog_s1_q;
            tog_s3_q <= tog_s2_q;
            arp_on_q <= arp_on_d;
            note_q   <= note_d;
            dir_q    <= dir_d;
            timer_q  <= timer_d;
            div_q    <= div_d;
            addra_q  <= addra_d;
            step_q   <= step_d;
            f_lat_q  <= f_lat_d;
        end
    end

`ifdef ARP_GATE_EN
    localparam logic [TMR_W-1:0] GATE_START = TMR_W'(NOTE_TICKS - GATE_TICKS);
    logic mute_q, mute_d;

    // Mute tracks the registered timer window so it aligns with timer_q.
    always_comb begin
        mute_d = arp_on_d && (timer_d >= GATE_START);
    end

    // Mute register; while set the sample stream is frozen.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            mute_q <= 1'b0;
        end else begin
            mute_q <= mute_d;
        end
    end

    assign run      = ~mute_q;
    assign bus.mute = mute_q;
`else
    assign run      = 1'b1;
    assign bus.mute = 1'b0;
`endif

    assign bus.addra     = addra_q;
    assign bus.addr_step = step_q;
    assign bus.note      = note_q;
    assign bus.arp_on    = arp_on_q;
endmodule

// File: tb/tb_arp_note_scheduler.sv
// tb_arp_note_scheduler: directed bench for arp_note_scheduler using a small
// address width (wrap reached quickly) and short arpeggio notes.
module tb_arp_note_scheduler;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_note = 0;
    int   per [4] = '{1492, 1193, 994, 746};
    int   up_seq [4] = '{1, 2, 3, 0};
    int   ud_seq [7] = '{1, 2, 3, 2, 1, 0, 1};
    int   dn_seq [5] = '{0, 3, 2, 1, 0};

    arp_note_scheduler_if #(.ADDR_W(3)) bus ();

    arp_note_scheduler #(
        .ADDR_W(3),
        .NOTE_TICKS(2000)
`ifdef ARP_GATE_EN
        ,
        .GATE_TICKS(300)
`endif
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic wait_step(input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.addr_step !== 1'b1 && k < limit);
        if (bus.addr_step !== 1'b1) check("step_timeout", int'(bus.addr_step), 1);
    endtask

    task automatic next_note(input string tag, input int exp_note);
        int prev;
        int k;
        prev = int'(bus.note);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (int'(bus.note) == prev && k < 3000);
        check({tag, "_note"}, int'(bus.note), exp_note);
        check({tag, "_len"}, cyc - t_note, 2000);
        t_note = cyc;
    endtask

    initial begin
        int s;
        int r;
        bus.arp_toggle = 1'b0;
        bus.base_sel   = 8'd0;
        bus.mode       = 2'b00;
        rst_n          = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addra", int'(bus.addra), 0);
        check("rst_step", int'(bus.addr_step), 0);
        check("rst_note", int'(bus.note), 0);
        check("rst_arp_on", int'(bus.arp_on), 0);
        check("rst_mute", int'(bus.mute), 0);

        // Free-running address stream at the base period, through the wrap.
        rst_n = 1'b1;
        r = cyc;
        wait_step(2500);
        check("t1_first_step", cyc - r, 1492);
        check("t1_addra", int'(bus.addra), 1);
        for (int i = 2; i <= 8; i++) begin
            s = cyc;
            wait_step(2500);
            check("t1_gap", cyc - s, 1492);
            check("t1_addra", int'(bus.addra), i % 8);
        end

        // base_sel change mid-sample only affects the following sample.
        s = cyc;
        repeat (500) @(negedge clk);
        bus.base_sel = 8'd255;
        wait_step(2500);
        check("t2_gap_old", cyc - s, 1492);
        s = cyc;
        wait_step(2500);
        check("t2_gap_new", cyc - s, 2002);
        s = cyc;
        bus.base_sel = 8'd0;
        wait_step(2500);
        check("t2_gap_latched", cyc - s, 2002);
        s = cyc;
        wait_step(2500);
        check("t2_gap_back", cyc - s, 1492);

        // Arpeggiator on, mode up.
        bus.arp_toggle = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_arp_on_2clk", int'(bus.arp_on), 0);
        @(negedge clk);
        check("t3_arp_on_3clk", int'(bus.arp_on), 1);
        t_note = cyc;
        for (int i = 0; i < 4; i++) begin
            next_note("up", up_seq[i]);
            wait_step(2500);
            check("up_first_step", cyc - t_note, per[up_seq[i]]);
            if (up_seq[i] == 3) begin
                s = cyc;
                wait_step(2500);
                check("up_note3_gap", cyc - s, 746);
            end
        end

        // Up-down, then down.
        bus.mode = 2'b10;
        for (int i = 0; i < 7; i++) next_note("updown", ud_seq[i]);
        bus.mode = 2'b01;
        for (int i = 0; i < 5; i++) next_note("down", dn_seq[i]);

        // Toggle off during note 2.
        bus.mode = 2'b00;
        next_note("t5_up", 1);
        next_note("t5_up", 2);
        repeat (500) @(negedge clk);
        check("t5_still_on", int'(bus.arp_on), 1);
        bus.arp_toggle = 1'b0;
        repeat (4) @(negedge clk);
        bus.arp_toggle = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_off_2clk", int'(bus.arp_on), 1);
        @(negedge clk);
        check("t5_off_arp_on", int'(bus.arp_on), 0);
        check("t5_off_note", int'(bus.note), 0);
        wait_step(2500);
        s = cyc;
        wait_step(2500);
        check("t5_off_gap", cyc - s, 1492);
        repeat (2100) @(negedge clk);
        check("t5_off_note_held", int'(bus.note), 0);

        // Toggle back on, then reset during note 3.
        bus.arp_toggle = 1'b0;
        repeat (4) @(negedge clk);
        bus.arp_toggle = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_on_again", int'(bus.arp_on), 1);
        t_note = cyc;
        next_note("t5_pre", 1);
        next_note("t5_pre", 2);
        next_note("t5_pre", 3);
        repeat (300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_addra", int'(bus.addra), 0);
        check("t5_rst_note", int'(bus.note), 0);
        check("t5_rst_arp_on", int'(bus.arp_on), 0);
        check("t5_rst_step", int'(bus.addr_step), 0);
        bus.arp_toggle = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        wait_step(2500);
        check("t5_rst_first_step", cyc - r, 1492);
        check("t5_rst_addra_after", int'(bus.addra), 1);
        check("t5_rst_arp_off", int'(bus.arp_on), 0);

`ifdef ARP_GATE_EN
        // End-of-note gate window: timer 1700..1999.
        begin
            int a;
            int bad;
            bus.arp_toggle = 1'b1;
            repeat (3) @(negedge clk);
            check("t6_arp_on", int'(bus.arp_on), 1);
            t_note = cyc;
            repeat (1699) @(negedge clk);
            check("t6_mute_before", int'(bus.mute), 0);
            @(negedge clk);
            check("t6_mute_start", int'(bus.mute), 1);
            a = int'(bus.addra);
            bad = 0;
            repeat (299) begin
                @(negedge clk);
                if (bus.addr_step !== 1'b0 || int'(bus.addra) != a || bus.mute !== 1'b1) bad++;
            end
            check("t6_frozen_window", bad, 0);
            @(negedge clk);
            check("t6_mute_end", int'(bus.mute), 0);
            check("t6_note_adv", int'(bus.note), 1);
            t_note = cyc;
            wait_step(2500);
            check("t6_resume_step", cyc - t_note, 1193);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/arp_note_scheduler.md
Name: arp_note_scheduler

Overview:
Controller for the sine-table audio datapath. Generates the block-RAM read address stream for the fixed-period sine lookup. Sequences an arpeggiator over four notes: root, 5/4, 3/2 and octave ratios. The external PWM stage consumes the BRAM data; this block only schedules address advance, note changes and the arpeggiator on/off state.

Parameters:
ADDR_W, 8, BRAM address width; addra wraps modulo 2^ADDR_W
DIV_W, 13, sample-period divider counter width
BASE_DIV, 746, base half-period added to base_sel
NOTE_TICKS, 50000000, clock cycles per arpeggio note (1 s at 100 MHz)
GATE_TICKS, 5000000, mute length at end of each note (optional feature only)

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous active-low reset
arp_toggle  in  1  debounced button level; each rising edge toggles arpeggiator
base_sel  in  8  pitch offset (switches), f_base = BASE_DIV + base_sel
mode  in  2  00 up, 01 down, 10 up-down, 11 hold
addra  out  ADDR_W  sine BRAM read address
addr_step  out  1  one-cycle pulse, registered with each addra advance
note  out  2  current note index, 0..3
arp_on  out  1  arpeggiator enabled
mute  out  1  audio mute request

Behaviour:
- Reset (async, CPU_RESETN=0): addra=0, addr_step=0, note=0, arp_on=0, mute=0, divider=0, note timer=0, up-down direction=up, f_lat=BASE_DIV. Sync flops clear.
- arp_toggle: 2-flop synchroniser plus rising-edge detect. arp_on flips on the 3rd clock edge after the input rises. Held level causes no further toggles.
- Period P for each note, from latched f_lat. Products are formed at 14+ bits before dividing, result floored:
  - note0: 2*f
  - note1: (8*f)/5
  - note2: (4*f)/3
  - note3: f
  - Example, f=746: 1492, 1193, 994, 746.
  - Example, f=1001: 2002, 1601, 1334, 1001.
- Divider: counts 0..P-1.
  - At P-1: divider<=0, addra<=addra+1 (255->0 wrap), addr_step=1 for that one cycle.
  - Steady-state addr_step spacing is exactly P cycles.
- f_lat reload: reloads from BASE_DIV+base_sel only on a divider wrap. A base_sel change never shortens or stretches the sample in progress.
- arp_on=0: note held at 0, note timer held at 0, direction=up; P uses note0.
- arp_on=1: note timer counts 0..NOTE_TICKS-1. At NOTE_TICKS-1 the timer clears and note advances per mode:
  - up: 0,1,2,3,0
  - down: 0,3,2,1,0
  - up-down: 0,1,2,3,2,1,0,1; direction reverses at 3 and at 0
  - hold: note unchanged
- On a note advance, the divider clears to 0 and the new P applies from the next cycle. addra is not reset, so the phase is continuous.
- Mode change mid-note: takes effect at the next advance. Entering up-down keeps the current direction register.
- Simultaneous events:
  - Divider wrap plus note advance in the same cycle: addra increments once, divider=0, new note period.
  - Toggle-off edge plus note advance in the same cycle: toggle wins. note=0, timer=0, direction=up.
  - Toggle-on: starts at note 0 with timer=0.
- Mid-operation reset: all state returns to reset values immediately, with no partial note continuing.

Optional Feature:
ARP_GATE_EN
- Defined:
  - While arp_on=1 and note timer >= NOTE_TICKS-GATE_TICKS: mute=1, divider and addra frozen, addr_step=0.
  - mute clears with the note advance.
  - When arp_on=0, mute is 0.
- Undefined: mute is constant 0 and no gate logic is synthesised.

Test Plan:
1. Reset release, base_sel=0, arp off -> first addr_step at cycle 1492, then every 1492; addra 0->1->2; after 256 steps addra=0.
2. base_sel=255 written mid-sample -> current sample keeps its old period; from the next wrap, spacing is 2002.
3. NOTE_TICKS=20000, mode=up, toggle on -> arp_on high 3 cycles after edge; note 0,1,2,3,0 every 20000 cycles; step spacing 1492,1193,994,746.
4. mode=10 (up-down) -> note sequence 0,1,2,3,2,1,0,1; mode=01 (down) from note 0 -> 3,2,1,0.
5. Toggle off during note 2, and CPU_RESETN pulse during note 3 -> both give note=0, spacing 1492. Reset additionally clears addra=0 and arp_on=0 asynchronously.
6. ARP_GATE_EN, NOTE_TICKS=20000, GATE_TICKS=2000 -> mute=1 for timer 18000..19999, addra constant and no addr_step during that window; mute=0 and stepping resumes on the next note.
